// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and the pixel-drawing logic.
// Latency: n/a (signal bundle only).
// Backpressure: none; the pixel strobe is free-running and outputs are held between pixels.
// Ports: pix_clk_in (strobe into the generator); pixel_tick, hsync, vsync, video_on,
//        x, y, line_start, frame_start (raster state out of the generator).
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          pix_clk_in;
  logic          pixel_tick;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  // master = the timing generator, slave = the consumer that draws pixels
  modport master (
    input  pix_clk_in,
    output pixel_tick, hsync, vsync, video_on, x, y, line_start, frame_start
  );
  modport slave (
    output pix_clk_in,
    input  pixel_tick, hsync, vsync, video_on, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: advances one pixel per rising edge of the pix_clk_in strobe.
// Latency: pix_clk_in rising at edge N -> pixel_tick and new x/y/syncs at edge N+1.
// Backpressure: none; with pix_clk_in constant nothing advances and outputs hold.
// Ports: clk system clock; rst async active-low; vga.master carries pix_clk_in in and
//        pixel_tick/hsync/vsync/video_on/x/y/line_start/frame_start out (all registered).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Segment boundaries: first coordinate of FP, SYNC and BP respectively.
  localparam logic [CW-1:0] H_T1   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_T2   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_T3   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_T1   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_T2   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_T3   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {S_ACT = 2'd0, S_FP = 2'd1, S_SYNC = 2'd2, S_BP = 2'd3} seg_e;

  // On a boundary crossing, land in the segment that actually contains the new
  // coordinate; this is what skips zero-length porch/sync segments.
  function automatic seg_e h_seg(input logic [CW-1:0] c);
    if (c < H_T1)      return S_ACT;
    else if (c < H_T2) return S_FP;
    else if (c < H_T3) return S_SYNC;
    else               return S_BP;
  endfunction

  function automatic seg_e v_seg(input logic [CW-1:0] c);
    if (c < V_T1)      return S_ACT;
    else if (c < V_T2) return S_FP;
    else if (c < V_T3) return S_SYNC;
    else               return S_BP;
  endfunction

  logic          pix_q;
  logic          tick;
  logic          armed, armed_nxt;
  logic [CW-1:0] h, h_nxt;
  logic [CW-1:0] v, v_nxt;
  logic          h_adv, h_wrap;
  seg_e          h_st, h_st_nxt;
  seg_e          v_st, v_st_nxt;
  logic          vid_d, hs_d, vs_d, ls_d, fs_d;

  assign tick = vga.pix_clk_in & ~pix_q;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q           <= 1'b0;
      armed           <= 1'b0;
      h               <= '0;
      v               <= '0;
      h_st            <= S_ACT;
      v_st            <= S_ACT;
      vga.pixel_tick  <= 1'b0;
      vga.hsync       <= ~SYNC_POL;
      vga.vsync       <= ~SYNC_POL;
      vga.video_on    <= 1'b0;
      vga.x           <= '0;
      vga.y           <= '0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      pix_q          <= vga.pix_clk_in;
      armed          <= armed_nxt;
      h              <= h_nxt;
      v              <= v_nxt;
      h_st           <= h_st_nxt;
      v_st           <= v_st_nxt;
      vga.pixel_tick <= tick;
      if (tick) begin
        vga.hsync       <= hs_d;
        vga.vsync       <= vs_d;
        vga.video_on    <= vid_d;
        vga.x           <= h_nxt;
        vga.y           <= v_nxt;
        vga.line_start  <= ls_d;
        vga.frame_start <= fs_d;
      end
    end
  end

  // Next-state logic for counters and the H/V segment FSMs.
  always_comb begin
    armed_nxt = armed;
    h_nxt     = h;
    v_nxt     = v;
    h_adv     = 1'b0;
    h_wrap    = 1'b0;
    h_st_nxt  = h_st;
    v_st_nxt  = v_st;
    if (tick) begin
      armed_nxt = 1'b1;
      // The first tick after reset only presents (0,0); counting starts after it.
      if (armed) begin
        h_adv = 1'b1;
        if (h == H_LAST) begin
          h_nxt  = '0;
          h_wrap = 1'b1;
          v_nxt  = (v == V_LAST) ? '0 : v + CW'(1);
        end else begin
          h_nxt = h + CW'(1);
        end
      end
    end
    if (h_adv && (h_nxt == H_T1 || h_nxt == H_T2 || h_nxt == H_T3 || h_nxt == '0))
      h_st_nxt = h_seg(h_nxt);
    if (h_wrap && (v_nxt == V_T1 || v_nxt == V_T2 || v_nxt == V_T3 || v_nxt == '0))
      v_st_nxt = v_seg(v_nxt);
  end

  // Output decode from the state the registers are about to take.
  always_comb begin
    vid_d = (h_st_nxt == S_ACT) && (v_st_nxt == S_ACT);
    hs_d  = (h_st_nxt == S_SYNC) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (v_st_nxt == S_SYNC) ? SYNC_POL : ~SYNC_POL;
    ls_d  = (h_nxt == '0);
    fs_d  = (h_nxt == '0) && (v_nxt == '0);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-timing instance (H 8/2/2/2, V 4/1/1/1) and a
// default 640x480 instance share clk, rst and the pix_clk_in strobe, and are compared
// every cycle against a pixel-index model plus a few literal expectations.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n = 0;        // ticks since the last reset release, counted by the driver
  logic prevp = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10)) vs_if ();
  vga_timing_gen_if #(.CW(10)) vb_if ();
  assign vs_if.pix_clk_in = pix;
  assign vb_if.pix_clk_in = pix;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .CW(10)
  ) dut_s (.clk(clk), .rst(rst), .vga(vs_if.master));

  vga_timing_gen dut_b (.clk(clk), .rst(rst), .vga(vb_if.master));

  typedef struct {
    int   x;
    int   y;
    logic vid;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } exp_t;

  // Pixel number kk since reset (kk<0: no tick yet) -> expected raster outputs.
  function automatic exp_t model(int kk, int ha, int hf, int hsn, int hb,
                                 int va, int vf, int vsn, int vb);
    exp_t e;
    int ht = ha + hf + hsn + hb;
    int vt = va + vf + vsn + vb;
    if (kk < 0) begin
      e.x = 0; e.y = 0; e.vid = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.ls = 1'b0; e.fs = 1'b0;
    end else begin
      e.x   = kk % ht;
      e.y   = (kk / ht) % vt;
      e.vid = (e.x < ha) && (e.y < va);
      e.hs  = !((e.x >= ha + hf) && (e.x < ha + hf + hsn));
      e.vs  = !((e.y >= va + vf) && (e.y < va + vf + vsn));
      e.ls  = (e.x == 0);
      e.fs  = (e.x == 0) && (e.y == 0);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state, updated at each active edge from the inputs the DUT samples there.
  int   k = -1;
  logic prev_pix = 1'b0;
  logic e_tick = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      k = -1; prev_pix = 1'b0; e_tick = 1'b0;
    end else begin
      e_tick   = pix && !prev_pix;
      prev_pix = pix;
      if (e_tick) k++;
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    exp_t es, eb;
    logic et;
    if (!rst) begin
      es = model(-1, 8, 2, 2, 2, 4, 1, 1, 1);
      eb = model(-1, 640, 16, 96, 48, 480, 10, 2, 33);
      et = 1'b0;
    end else begin
      es = model(k, 8, 2, 2, 2, 4, 1, 1, 1);
      eb = model(k, 640, 16, 96, 48, 480, 10, 2, 33);
      et = e_tick;
    end
    chk("s_tick", vs_if.pixel_tick, et);
    chk("s_x", vs_if.x, es.x);
    chk("s_y", vs_if.y, es.y);
    chk("s_video_on", vs_if.video_on, es.vid);
    chk("s_hsync", vs_if.hsync, es.hs);
    chk("s_vsync", vs_if.vsync, es.vs);
    chk("s_line_start", vs_if.line_start, es.ls);
    chk("s_frame_start", vs_if.frame_start, es.fs);
    chk("b_tick", vb_if.pixel_tick, et);
    chk("b_x", vb_if.x, eb.x);
    chk("b_y", vb_if.y, eb.y);
    chk("b_video_on", vb_if.video_on, eb.vid);
    chk("b_hsync", vb_if.hsync, eb.hs);
    chk("b_vsync", vb_if.vsync, eb.vs);
    chk("b_line_start", vb_if.line_start, eb.ls);
    chk("b_frame_start", vb_if.frame_start, eb.fs);
  end

  // One full strobe period with randomized high/low lengths; ends just after an edge.
  task automatic do_tick();
    pix = 1'b1;
    repeat ($urandom_range(1, 2)) @(posedge clk);
    #1;
    pix = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  initial begin
    int need;
    int xh;
    // Reset held with the strobe toggling.
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; pix = ~pix; end
    chk("lit_rst_hsync", vb_if.hsync, 1);
    chk("lit_rst_vsync", vb_if.vsync, 1);
    chk("lit_rst_tick", vb_if.pixel_tick, 0);
    chk("lit_rst_x", vb_if.x, 0);

    @(posedge clk); #1; pix = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    // First tick after release shows pixel (0,0).
    pix = 1'b1;
    @(posedge clk); #1;
    n = 1;
    chk("lit_first_tick", vb_if.pixel_tick, 1);
    chk("lit_first_x", vb_if.x, 0);
    chk("lit_first_y", vb_if.y, 0);
    chk("lit_first_vid", vb_if.video_on, 1);
    chk("lit_first_ls", vb_if.line_start, 1);
    chk("lit_first_fs", vb_if.frame_start, 1);
    pix = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 820; i++) begin
      do_tick();
      n++;
      if (n == 11) begin
        chk("lit_s_x10", vs_if.x, 10);
        chk("lit_s_hsync_x10", vs_if.hsync, 0);
      end
      if (n == 15) begin
        chk("lit_s_wrap_x", vs_if.x, 0);
        chk("lit_s_wrap_y", vs_if.y, 1);
        chk("lit_s_wrap_ls", vs_if.line_start, 1);
      end
      if (n == 71) begin
        chk("lit_s_y5", vs_if.y, 5);
        chk("lit_s_vsync_y5", vs_if.vsync, 0);
        chk("lit_s_vid_y5", vs_if.video_on, 0);
      end
      if (n == 99) chk("lit_s_frame", vs_if.frame_start, 1);
      if (n == 800) begin
        chk("lit_b_x799", vb_if.x, 799);
        chk("lit_b_hsync_x799", vb_if.hsync, 1);
        chk("lit_b_vid_x799", vb_if.video_on, 0);
      end
      if (n == 801) begin
        chk("lit_b_line_x", vb_if.x, 0);
        chk("lit_b_line_y", vb_if.y, 1);
        chk("lit_b_line_ls", vb_if.line_start, 1);
        chk("lit_b_line_fs", vb_if.frame_start, 0);
      end
    end

    // Strobe held high mid-line: exactly one tick, then nothing moves.
    pix = 1'b1;
    @(posedge clk); #1;
    n++;
    repeat (50) @(posedge clk);
    #1;
    xh = (n - 1) % 800;
    chk("lit_hold_tick", vb_if.pixel_tick, 0);
    chk("lit_hold_x", vb_if.x, xh);
    chk("lit_hold_y", vb_if.y, ((n - 1) / 800) % 525);
    pix = 1'b0;
    @(posedge clk); #1;

    // Free-running random strobe.
    prevp = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      pix = 1'($urandom_range(0, 1));
      if (pix && !prevp) n++;
      prevp = pix;
      @(posedge clk); #1;
    end
    pix = 1'b0;
    @(posedge clk); #1;

    // Walk to x=700 (inside hsync) and reset there.
    need = (700 - ((n - 1) % 800) + 800) % 800;
    for (int i = 0; i < need; i++) begin do_tick(); n++; end
    chk("lit_x700", vb_if.x, 700);
    chk("lit_hsync_x700", vb_if.hsync, 0);
    rst = 1'b0;
    #1;
    chk("lit_rst_mid_hsync", vb_if.hsync, 1);
    chk("lit_rst_mid_x", vb_if.x, 0);
    chk("lit_rst_mid_vid", vb_if.video_on, 0);
    repeat (5) begin @(posedge clk); #1; pix = ~pix; end
    pix = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    pix = 1'b1;
    @(posedge clk); #1;
    n = 1;
    chk("lit_rerst_x", vb_if.x, 0);
    chk("lit_rerst_y", vb_if.y, 0);
    chk("lit_rerst_fs", vb_if.frame_start, 1);
    chk("lit_rerst_s_fs", vs_if.frame_start, 1);
    pix = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 150; i++) begin do_tick(); n++; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
